hazard_responder: RTL and testbench
===================================

Name: hazard_responder

Overview:
- Consumer side of the decode-stage hazard unit. It takes that unit's fetch_stall and bypass-select codes and acts on them.
- Acting on them means: gate PC and F/D register enables, inject D/E bubbles, carry bypass selects down the pipe, and apply the operand muxes in E and the store-data mux in M.
- Also owns redirect flush sequencing and a stall watchdog.

Parameters:
- XLEN, 32, datapath width.
- MAX_STALL, 3, consecutive stall cycles that trip the watchdog.
- CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_stall  in  1  hazard unit stall request
- rs1_bypass  in  2  D-stage rs1 select: 0 regfile, 1 M result, 3 W data
- rs2_bypass  in  3  D-stage rs2 select: 0 regfile, 1 M result, 3 W data, 4 store data from W into M
- redirect_e  in  1  taken branch/jump resolved in E
- rs1_data_d  in  XLEN  regfile rs1 read
- rs2_data_d  in  XLEN  regfile rs2 read
- result_m  in  XLEN  ALU result of the instruction in M
- wb_data_w  in  XLEN  writeback value in W
- pc_en  out  1  PC register enable
- fd_en  out  1  F/D register enable
- fd_flush  out  1  F/D register clear to NOP
- de_bubble  out  1  D/E register loads NOP
- valid_e  out  1  E-stage instruction valid
- rs1_val_e  out  XLEN  forwarded rs1 operand in E
- rs2_val_e  out  XLEN  forwarded rs2 operand in E
- store_data_m  out  XLEN  store data in M
- state  out  2  00 RUN, 01 STALL, 10 FLUSH
- hazard_error  out  1  sticky watchdog flag

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - state=RUN, valid_e=0, hazard_error=0.
  - Internal select registers sel1_e=0, sel2_e=0, sel2_m=0.
  - Data registers and counters 0.
  - Reset mid-stall or mid-flush aborts to RUN on the next edge.
- FSM transitions, evaluated in priority order each cycle:
  - redirect_e=1 goes to FLUSH from any state.
  - From FLUSH, go to RUN unconditionally. fetch_stall is ignored in FLUSH because D holds a flushed NOP.
  - From RUN or STALL: fetch_stall=1 goes to STALL, else RUN.
- Combinational control, from current inputs and state:
  - redirect_e=1: pc_en=1, fd_en=1, fd_flush=1, de_bubble=1. Redirect beats stall.
  - Else fetch_stall=1 and state!=FLUSH: pc_en=0, fd_en=0, fd_flush=0, de_bubble=1.
  - Else: pc_en=1, fd_en=1, fd_flush=0, de_bubble=0.
- D/E register, updated every edge:
  - If de_bubble: valid_e<=0, sel1_e<=0, sel2_e<=0, data<=0.
  - Else: valid_e<=1 and capture rs1_bypass, rs2_bypass, rs1_data_d, rs2_data_d.
- E-stage mux, combinational:
  - sel 1 selects result_m; sel 3 selects wb_data_w; 0 or any other code selects the captured regfile data.
  - For rs2, code 4 leaves rs2_val_e equal to the captured regfile data.
- E/M register, updated every edge:
  - sel2_m<=sel2_e and store_data_pre<=rs2_val_e.
  - If redirect_e=1, sel2_m is still captured; the branch itself proceeds.
- M-stage store mux: store_data_m = wb_data_w when sel2_m==4, else store_data_pre.
- One-cycle latency from a D-stage select to its E-stage use; two cycles to its M-stage use.
- Watchdog:
  - stall_run counter increments each cycle with fetch_stall=1 and state!=FLUSH; clears otherwise; saturates at MAX_STALL.
  - On reaching MAX_STALL, hazard_error<=1. It stays set until reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W] and flush_cycles[CNT_W].
  - stall_cycles increments on cycles with de_bubble=1 and redirect_e=0.
  - flush_cycles increments on redirect_e=1.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted for 2 cycles while fetch_stall=1 -> state=00, valid_e=0, hazard_error=0, pc_en=0 combinationally. After release with fetch_stall=0 -> pc_en=1, next edge valid_e=1.
- rs1_bypass=1, rs1_data_d=0x11, result_m=0x22 next cycle -> rs1_val_e=0x22. Repeat with code 3 and wb_data_w=0x33 -> 0x33. Code 0 -> 0x11.
- rs2_bypass=4, rs2_data_d=0x5, then wb_data_w=0xABCD two cycles later -> rs2_val_e=0x5 in E, store_data_m=0xABCD in M.
- fetch_stall=1 for one cycle -> pc_en=0, fd_en=0, de_bubble=1. Next edge state=01, valid_e=0. Then fetch_stall=0 -> state=00.
- fetch_stall=1 and redirect_e=1 together -> pc_en=1, fd_flush=1, state=10. Next cycle with fetch_stall=1 -> de_bubble=0, state=00.
- fetch_stall held 3 cycles (MAX_STALL=3) -> hazard_error=1 after the 3rd edge; it stays 1 after the stall drops until reset.

Source files
------------

// File: rtl/hazard_responder_if.sv
// Hazard-unit control and decode/forwarding datapath bundle for hazard_responder.
// The master modport drives the hazard unit's requests and operands; the slave modport is the responder.
interface hazard_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_stall;
    logic [1:0]      rs1_bypass;
    logic [2:0]      rs2_bypass;
    logic            redirect_e;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_d;
    logic [XLEN-1:0] result_m;
    logic [XLEN-1:0] wb_data_w;
    logic            pc_en;
    logic            fd_en;
    logic            fd_flush;
    logic            de_bubble;
    logic            valid_e;
    logic [XLEN-1:0] rs1_val_e;
    logic [XLEN-1:0] rs2_val_e;
    logic [XLEN-1:0] store_data_m;
    logic [1:0]      state;
    logic            hazard_error;

    modport master (
        output fetch_stall, rs1_bypass, rs2_bypass, redirect_e,
        output rs1_data_d, rs2_data_d, result_m, wb_data_w,
        input  pc_en, fd_en, fd_flush, de_bubble, valid_e,
        input  rs1_val_e, rs2_val_e, store_data_m, state, hazard_error
    );

    modport slave (
        input  fetch_stall, rs1_bypass, rs2_bypass, redirect_e,
        input  rs1_data_d, rs2_data_d, result_m, wb_data_w,
        output pc_en, fd_en, fd_flush, de_bubble, valid_e,
        output rs1_val_e, rs2_val_e, store_data_m, state, hazard_error
    );
endinterface

// File: rtl/hazard_responder.sv
// Acts on decode-stage hazard decisions: stall/flush gating, bypass muxing in E and M, stall watchdog.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles/flush_cycles performance counters.
module hazard_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MAX_STALL = 3
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,
    hazard_responder_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
`endif
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              pc_en_c;
    logic              fd_en_c;
    logic              fd_flush_c;
    logic              de_bubble_c;
    logic              stall_cond_c;

    logic              valid_e_q;
    logic [1:0]        sel1_e;
    logic [2:0]        sel2_e;
    logic [XLEN-1:0]   rs1_reg_e;
    logic [XLEN-1:0]   rs2_reg_e;
    logic [XLEN-1:0]   rs1_val_c;
    logic [XLEN-1:0]   rs2_val_c;

    logic [2:0]        sel2_m;
    logic [XLEN-1:0]   store_data_pre;

    logic [RUN_W-1:0]  stall_run;
    logic [RUN_W-1:0]  stall_run_d;
    logic              hazard_error_q;

    // Next state and pipeline gating; redirect outranks stall, and a flushed D ignores stall.
    always_comb begin
        state_d     = state_q;
        pc_en_c     = 1'b1;
        fd_en_c     = 1'b1;
        fd_flush_c  = 1'b0;
        de_bubble_c = 1'b0;
        if (bus.redirect_e) begin
            state_d     = ST_FLUSH;
            fd_flush_c  = 1'b1;
            de_bubble_c = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
        end else if (bus.fetch_stall) begin
            state_d     = ST_STALL;
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            de_bubble_c = 1'b1;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // D/E register: a bubble clears valid, selects and data.
    always_ff @(posedge clock) begin
        if (reset || de_bubble_c) begin
            valid_e_q <= 1'b0;
            sel1_e    <= 2'd0;
            sel2_e    <= 3'd0;
            rs1_reg_e <= '0;
            rs2_reg_e <= '0;
        end else begin
            valid_e_q <= 1'b1;
            sel1_e    <= bus.rs1_bypass;
            sel2_e    <= bus.rs2_bypass;
            rs1_reg_e <= bus.rs1_data_d;
            rs2_reg_e <= bus.rs2_data_d;
        end
    end

    // E-stage operand forwarding; code 4 on rs2 is resolved later in M.
    always_comb begin
        rs1_val_c = rs1_reg_e;
        rs2_val_c = rs2_reg_e;
        case (sel1_e)
            2'd1:    rs1_val_c = bus.result_m;
            2'd3:    rs1_val_c = bus.wb_data_w;
            default: rs1_val_c = rs1_reg_e;
        endcase
        case (sel2_e)
            3'd1:    rs2_val_c = bus.result_m;
            3'd3:    rs2_val_c = bus.wb_data_w;
            default: rs2_val_c = rs2_reg_e;
        endcase
    end

    // E/M register is never bubbled: the redirecting branch itself still proceeds.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel2_m         <= 3'd0;
            store_data_pre <= '0;
        end else begin
            sel2_m         <= sel2_e;
            store_data_pre <= rs2_val_c;
        end
    end

    // Watchdog: consecutive effective stall cycles, saturating, with a sticky error.
    assign stall_cond_c = bus.fetch_stall && (state_q != ST_FLUSH);

    always_comb begin
        stall_run_d = '0;
        if (stall_cond_c) begin
            stall_run_d = (stall_run == RUN_W'(MAX_STALL)) ? stall_run : stall_run + RUN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_run      <= '0;
            hazard_error_q <= 1'b0;
        end else begin
            stall_run <= stall_run_d;
            if (stall_run_d == RUN_W'(MAX_STALL)) begin
                hazard_error_q <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (de_bubble_c && !bus.redirect_e) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (bus.redirect_e) begin
                flush_cycles <= flush_cycles + CNT_W'(1);
            end
        end
    end
`endif

    assign bus.pc_en        = pc_en_c;
    assign bus.fd_en        = fd_en_c;
    assign bus.fd_flush     = fd_flush_c;
    assign bus.de_bubble    = de_bubble_c;
    assign bus.valid_e      = valid_e_q;
    assign bus.rs1_val_e    = rs1_val_c;
    assign bus.rs2_val_e    = rs2_val_c;
    assign bus.store_data_m = (sel2_m == 3'd4) ? bus.wb_data_w : store_data_pre;
    assign bus.state        = state_q;
    assign bus.hazard_error = hazard_error_q;

endmodule

// File: tb/tb_hazard_responder.sv
// Directed self-checking bench for hazard_responder: reset, forwarding, stall, redirect and watchdog.
module tb_hazard_responder;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    hazard_responder_if #(.XLEN(32)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;
`endif

    hazard_responder #(.XLEN(32), .MAX_STALL(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.fetch_stall = 1'b1; bus.redirect_e = 1'b0;
        bus.rs1_bypass = 2'd0; bus.rs2_bypass = 3'd0;
        bus.rs1_data_d = '0; bus.rs2_data_d = '0; bus.result_m = '0; bus.wb_data_w = '0;
        tick();
        tick();
        #1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.state); end
        checks++; if (bus.valid_e !== 1'b0) begin errors++; $display("FAIL reset_valid_e: got %b expected 0", bus.valid_e); end
        checks++; if (bus.hazard_error !== 1'b0) begin errors++; $display("FAIL reset_hazard_error: got %b expected 0", bus.hazard_error); end
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en_stall: got %b expected 0", bus.pc_en); end
        reset = 1'b0;
        bus.fetch_stall = 1'b0;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL release_pc_en: got %b expected 1", bus.pc_en); end
        tick();
        checks++; if (bus.valid_e !== 1'b1) begin errors++; $display("FAIL release_valid_e: got %b expected 1", bus.valid_e); end
    endtask

    task automatic test_rs1_forward();
        bus.rs1_bypass = 2'd1; bus.rs1_data_d = 32'h11;
        tick();
        bus.result_m = 32'h22;
        bus.rs1_bypass = 2'd3;
        #1;
        checks++; if (bus.rs1_val_e !== 32'h22) begin errors++; $display("FAIL rs1_sel1: got %h expected 00000022", bus.rs1_val_e); end
        tick();
        bus.wb_data_w = 32'h33;
        bus.rs1_bypass = 2'd0;
        #1;
        checks++; if (bus.rs1_val_e !== 32'h33) begin errors++; $display("FAIL rs1_sel3: got %h expected 00000033", bus.rs1_val_e); end
        tick();
        #1;
        checks++; if (bus.rs1_val_e !== 32'h11) begin errors++; $display("FAIL rs1_sel0: got %h expected 00000011", bus.rs1_val_e); end
    endtask

    task automatic test_store_forward();
        bus.rs2_bypass = 3'd4; bus.rs2_data_d = 32'h5;
        tick();
        bus.rs2_bypass = 3'd0; bus.rs2_data_d = 32'h66;
        #1;
        checks++; if (bus.rs2_val_e !== 32'h5) begin errors++; $display("FAIL rs2_sel4_e: got %h expected 00000005", bus.rs2_val_e); end
        tick();
        bus.wb_data_w = 32'hABCD;
        #1;
        checks++; if (bus.store_data_m !== 32'hABCD) begin errors++; $display("FAIL store_sel4_m: got %h expected 0000abcd", bus.store_data_m); end
        tick();
        #1;
        checks++; if (bus.store_data_m !== 32'h66) begin errors++; $display("FAIL store_sel0_m: got %h expected 00000066", bus.store_data_m); end
    endtask

    task automatic test_stall();
        bus.fetch_stall = 1'b1;
        bus.rs1_bypass = 2'd1; bus.rs1_data_d = 32'h77; bus.result_m = 32'h22;
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL stall_pc_en: got %b expected 0", bus.pc_en); end
        checks++; if (bus.fd_en !== 1'b0) begin errors++; $display("FAIL stall_fd_en: got %b expected 0", bus.fd_en); end
        checks++; if (bus.de_bubble !== 1'b1) begin errors++; $display("FAIL stall_de_bubble: got %b expected 1", bus.de_bubble); end
        checks++; if (bus.fd_flush !== 1'b0) begin errors++; $display("FAIL stall_fd_flush: got %b expected 0", bus.fd_flush); end
        tick();
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL stall_state: got %b expected 01", bus.state); end
        checks++; if (bus.valid_e !== 1'b0) begin errors++; $display("FAIL stall_valid_e: got %b expected 0", bus.valid_e); end
        checks++; if (bus.rs1_val_e !== 32'h0) begin errors++; $display("FAIL stall_bubble_rs1: got %h expected 00000000", bus.rs1_val_e); end
        bus.fetch_stall = 1'b0; bus.rs1_bypass = 2'd0;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL unstall_pc_en: got %b expected 1", bus.pc_en); end
        tick();
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL unstall_state: got %b expected 00", bus.state); end
        checks++; if (bus.rs1_val_e !== 32'h77) begin errors++; $display("FAIL unstall_rs1: got %h expected 00000077", bus.rs1_val_e); end
    endtask

    task automatic test_redirect();
        bus.fetch_stall = 1'b1; bus.redirect_e = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL redirect_pc_en: got %b expected 1", bus.pc_en); end
        checks++; if (bus.fd_flush !== 1'b1) begin errors++; $display("FAIL redirect_fd_flush: got %b expected 1", bus.fd_flush); end
        checks++; if (bus.de_bubble !== 1'b1) begin errors++; $display("FAIL redirect_de_bubble: got %b expected 1", bus.de_bubble); end
        tick();
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL redirect_state: got %b expected 10", bus.state); end
        bus.redirect_e = 1'b0;
        #1;
        checks++; if (bus.de_bubble !== 1'b0) begin errors++; $display("FAIL flush_ignores_stall: got %b expected 0", bus.de_bubble); end
        tick();
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL flush_to_run: got %b expected 00", bus.state); end
        checks++; if (bus.valid_e !== 1'b1) begin errors++; $display("FAIL flush_valid_e: got %b expected 1", bus.valid_e); end
        bus.fetch_stall = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        bus.fetch_stall = 1'b1;
        tick();
        tick();
        checks++; if (bus.hazard_error !== 1'b0) begin errors++; $display("FAIL wd_early: got %b expected 0", bus.hazard_error); end
        tick();
        checks++; if (bus.hazard_error !== 1'b1) begin errors++; $display("FAIL wd_trip: got %b expected 1", bus.hazard_error); end
        bus.fetch_stall = 1'b0;
        tick();
        tick();
        checks++; if (bus.hazard_error !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", bus.hazard_error); end
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL wd_state: got %b expected 00", bus.state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.hazard_error !== 1'b0) begin errors++; $display("FAIL wd_cleared: got %b expected 0", bus.hazard_error); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_stall_reset: got %0d expected 0", stall_cycles); end
        bus.redirect_e = 1'b1;
        tick();
        bus.redirect_e = 1'b0;
        checks++; if (flush_cycles !== 16'd1) begin errors++; $display("FAIL perf_flush: got %0d expected 1", flush_cycles); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_stall_on_flush: got %0d expected 0", stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_rs1_forward();
        test_store_forward();
        test_stall();
        test_redirect();
        test_watchdog();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
